// File: rtl/guess_scorer.sv
// Mastermind guess scorer: scores committed guesses against a hidden 4-digit secret,
// tracks turns and win/lose, and generates the secret from a free-running LFSR.
module guess_scorer #(
  parameter int NUM_COLORS = 6,
  parameter int MAX_TURNS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        load_secret,
  input  logic [11:0] secret_in,
  input  logic        score_req,
  input  logic [2:0]  guess3,
  input  logic [2:0]  guess2,
  input  logic [2:0]  guess1,
  input  logic [2:0]  guess0,
  output logic [2:0]  exact,
  output logic [2:0]  partial,
  output logic        score_valid,
  output logic        busy,
  output logic [3:0]  turns_used,
  output logic        win,
  output logic        lose,
  output logic [11:0] reveal,
  output logic [2:0]  dbg_state
);

  // Control inputs are single-cycle pulses with no backpressure: score_req is only
  // accepted in READY (otherwise dropped), and score_valid is a one-cycle pulse.
  typedef enum logic [2:0] {
    S_NO_GAME = 3'd0,
    S_GEN     = 3'd1,
    S_READY   = 3'd2,
    S_EXACT   = 3'd3,
    S_COUNT   = 3'd4,
    S_DONE    = 3'd5,
    S_OVER    = 3'd6
  } state_e;

  localparam logic [3:0]  NC        = 4'(NUM_COLORS);
  localparam logic [2:0]  LAST_C    = 3'(NUM_COLORS - 1);
  localparam logic [3:0]  MAX_T     = 4'(MAX_TURNS);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [11:0] secret_q, secret_d;
  logic [11:0] guess_q, guess_d;
  logic [3:0]  match_q, match_d;
  logic [2:0]  cnt_q, cnt_d;        // GEN digit index, or COUNT colour
  logic [2:0]  ex_acc_q, ex_acc_d;
  logic [2:0]  pa_acc_q, pa_acc_d;
  logic [2:0]  exact_q, exact_d;
  logic [2:0]  partial_q, partial_d;
  logic        sv_q, sv_d;
  logic [3:0]  turns_q, turns_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;

  logic [3:0]  gen_sub;
  logic [2:0]  gen_digit;
  logic [3:0]  eq_mask;
  logic [2:0]  mask_pop;
  logic [2:0]  sec_hits;
  logic [2:0]  gue_hits;
  logic [2:0]  color_min;

  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

  // Datapath helpers: folded LFSR digit, position match mask, per-colour unmatched counts.
  always_comb begin
    gen_sub   = {1'b0, lfsr_q[2:0]} - NC;
    gen_digit = ({1'b0, lfsr_q[2:0]} >= NC) ? gen_sub[2:0] : lfsr_q[2:0];
    eq_mask   = '0;
    mask_pop  = '0;
    sec_hits  = '0;
    gue_hits  = '0;
    for (int p = 0; p < 4; p++) begin
      eq_mask[p] = (secret_q[3*p +: 3] == guess_q[3*p +: 3]);
      mask_pop   = mask_pop + {2'b00, eq_mask[p]};
      if (!match_q[p] && (secret_q[3*p +: 3] == cnt_q)) sec_hits = sec_hits + 3'd1;
      if (!match_q[p] && (guess_q[3*p +: 3] == cnt_q))  gue_hits = gue_hits + 3'd1;
    end
    color_min = (sec_hits < gue_hits) ? sec_hits : gue_hits;
  end

  always_comb begin
    state_d   = state_q;
    secret_d  = secret_q;
    guess_d   = guess_q;
    match_d   = match_q;
    cnt_d     = cnt_q;
    ex_acc_d  = ex_acc_q;
    pa_acc_d  = pa_acc_q;
    exact_d   = exact_q;
    partial_d = partial_q;
    sv_d      = 1'b0;
    turns_d   = turns_q;
    win_d     = win_q;
    lose_d    = lose_q;
    if (load_secret || new_game) begin
      win_d     = 1'b0;
      lose_d    = 1'b0;
      turns_d   = '0;
      exact_d   = '0;
      partial_d = '0;
      cnt_d     = '0;
      if (load_secret) begin
        secret_d = secret_in;
        state_d  = S_READY;
      end else begin
        state_d  = S_GEN;
      end
    end else begin
      case (state_q)
        S_GEN: begin
          for (int k = 0; k < 4; k++) begin
            if (cnt_q[1:0] == 2'(k)) secret_d[3*k +: 3] = gen_digit;
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) state_d = S_READY;
        end
        S_READY: begin
          if (score_req) begin
            guess_d = {guess3, guess2, guess1, guess0};
            state_d = S_EXACT;
          end
        end
        S_EXACT: begin
          match_d  = eq_mask;
          ex_acc_d = mask_pop;
          pa_acc_d = '0;
          cnt_d    = '0;
          state_d  = S_COUNT;
        end
        S_COUNT: begin
          pa_acc_d = pa_acc_q + color_min;
          if (cnt_q == LAST_C) state_d = S_DONE;
          else                 cnt_d   = cnt_q + 3'd1;
        end
        S_DONE: begin
          exact_d   = ex_acc_q;
          partial_d = pa_acc_q;
          sv_d      = 1'b1;
          turns_d   = turns_q + 4'd1;
          if (ex_acc_q == 3'd4) begin
            win_d   = 1'b1;
            state_d = S_OVER;
          end else if ((turns_q + 4'd1) == MAX_T) begin
            lose_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            state_d = S_READY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_NO_GAME;
      lfsr_q    <= LFSR_SEED;
      secret_q  <= '0;
      guess_q   <= '0;
      match_q   <= '0;
      cnt_q     <= '0;
      ex_acc_q  <= '0;
      pa_acc_q  <= '0;
      exact_q   <= '0;
      partial_q <= '0;
      sv_q      <= 1'b0;
      turns_q   <= '0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      secret_q  <= secret_d;
      guess_q   <= guess_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      ex_acc_q  <= ex_acc_d;
      pa_acc_q  <= pa_acc_d;
      exact_q   <= exact_d;
      partial_q <= partial_d;
      sv_q      <= sv_d;
      turns_q   <= turns_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
    end
  end

  assign exact       = exact_q;
  assign partial     = partial_q;
  assign score_valid = sv_q;
  assign busy        = (state_q == S_GEN) || (state_q == S_EXACT) ||
                       (state_q == S_COUNT) || (state_q == S_DONE);
  assign turns_used  = turns_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign reveal      = (win_q || lose_q) ? secret_q : 12'h000;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Self-checking bench for guess_scorer: directed vector table, multi-cycle corner
// sequences, and randomized games checked against a histogram-based scoring model.
module tb_guess_scorer;

  localparam int NC  = 6;
  localparam int MT  = 8;
  localparam int LAT = NC + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_game = 1'b0;
  logic        load_secret = 1'b0;
  logic [11:0] secret_in = '0;
  logic        score_req = 1'b0;
  logic [2:0]  guess3 = '0, guess2 = '0, guess1 = '0, guess0 = '0;
  logic [2:0]  exact, partial;
  logic        score_valid, busy, win, lose;
  logic [3:0]  turns_used;
  logic [11:0] reveal;
  logic [2:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [5:0]  exp_q[$];
  logic [5:0]  mon_e;
  logic [15:0] m_lfsr;

  typedef struct {
    logic [11:0] secret;
    logic [11:0] guess;
    int          ex;
    int          pa;
  } vec_t;
  vec_t vecs[8];

  guess_scorer #(.NUM_COLORS(NC), .MAX_TURNS(MT)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .load_secret(load_secret),
    .secret_in(secret_in), .score_req(score_req),
    .guess3(guess3), .guess2(guess2), .guess1(guess1), .guess0(guess0),
    .exact(exact), .partial(partial), .score_valid(score_valid), .busy(busy),
    .turns_used(turns_used), .win(win), .lose(lose), .reveal(reveal),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference LFSR, stepped on every edge exactly as the secret generator's source.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  function automatic logic [11:0] dig(input int d3, input int d2, input int d1, input int d0);
    return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  // Score model: exact positions, then colour histograms of the leftover digits.
  function automatic logic [5:0] model_score(input logic [11:0] s, input logic [11:0] g);
    int ex;
    int pa;
    int hs[8];
    int hg[8];
    ex = 0;
    pa = 0;
    for (int c = 0; c < 8; c++) begin
      hs[c] = 0;
      hg[c] = 0;
    end
    for (int p = 0; p < 4; p++) begin
      if (s[3*p +: 3] == g[3*p +: 3]) ex++;
      else begin
        hs[s[3*p +: 3]]++;
        hg[g[3*p +: 3]]++;
      end
    end
    for (int c = 0; c < NC; c++) pa += (hs[c] < hg[c]) ? hs[c] : hg[c];
    return {3'(ex), 3'(pa)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every score_valid pulse must match the oldest expected score.
  always @(negedge clk) begin
    if (score_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_score_valid: got exact=%0d partial=%0d expected no pulse",
                 exact, partial);
      end else begin
        mon_e = exp_q.pop_front();
        check("score_exact", int'(exact), int'(mon_e[5:3]));
        check("score_partial", int'(partial), int'(mon_e[2:0]));
      end
    end
  end

  // Driver tasks: entered at a falling edge, return at a falling edge.
  task automatic do_load(input logic [11:0] s);
    secret_in   = s;
    load_secret = 1'b1;
    @(negedge clk);
    load_secret = 1'b0;
  endtask

  task automatic do_new_game(output logic [11:0] gen);
    logic [2:0] v;
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    gen = '0;
    for (int k = 0; k < 4; k++) begin
      v = m_lfsr[2:0];
      gen[3*k +: 3] = (int'(v) >= NC) ? v - 3'(NC) : v;
      check("gen_busy", int'(busy), 1);
      @(negedge clk);
    end
    check("gen_done_busy", int'(busy), 0);
  endtask

  task automatic drive_req(input logic [11:0] g);
    {guess3, guess2, guess1, guess0} = g;
    score_req = 1'b1;
    @(negedge clk);
    score_req = 1'b0;
  endtask

  task automatic run_score(input logic [11:0] g, input bit expect_pulse,
                           input logic [5:0] exp_sc, input string tag);
    int lat;
    int busy_first;
    int busy_at;
    lat = -1;
    busy_first = 0;
    busy_at = 1;
    if (expect_pulse) exp_q.push_back(exp_sc);
    drive_req(g);
    for (int i = 1; i <= LAT + 6; i++) begin
      if (i == 1) busy_first = int'(busy);
      if (score_valid && lat < 0) begin
        lat = i - 1;
        busy_at = int'(busy);
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, expect_pulse ? LAT : -1);
    check({tag, "_busy_rise"}, busy_first, int'(expect_pulse));
    if (expect_pulse) check({tag, "_busy_fall"}, busy_at, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_exact"}, int'(exact), 0);
    check({tag, "_partial"}, int'(partial), 0);
    check({tag, "_score_valid"}, int'(score_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_turns"}, int'(turns_used), 0);
    check({tag, "_win"}, int'(win), 0);
    check({tag, "_lose"}, int'(lose), 0);
    check({tag, "_reveal"}, int'(reveal), 0);
  endtask

  initial begin
    logic [11:0] gen;
    logic [11:0] s;
    logic [11:0] g;
    logic [5:0]  sc;
    int          pulses;

    vecs[0] = '{dig(1,1,2,2), dig(1,2,1,0), 1, 2};
    vecs[1] = '{dig(0,0,0,0), dig(5,5,5,5), 0, 0};
    vecs[2] = '{dig(5,4,3,2), dig(7,7,6,6), 0, 0};
    vecs[3] = '{dig(1,2,3,4), dig(2,1,4,3), 0, 4};
    vecs[4] = '{dig(0,1,2,3), dig(0,0,1,1), 1, 1};
    vecs[5] = '{dig(2,2,2,5), dig(2,5,5,2), 1, 2};
    vecs[6] = '{dig(5,5,0,0), dig(0,0,5,5), 0, 4};
    vecs[7] = '{dig(7,3,3,1), dig(7,1,3,3), 2, 2};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", int'(dbg_state), 0);
    reset = 1'b0;
    run_score(dig(1,2,3,4), 1'b0, '0, "nogame_ignored");

    // Win on first guess, then requests in OVER are dropped.
    do_load(dig(1,2,3,4));
    run_score(dig(1,2,3,4), 1'b1, {3'd4, 3'd0}, "win");
    check("win_flag", int'(win), 1);
    check("win_reveal", int'(reveal), 'h29C);
    check("win_turns", int'(turns_used), 1);
    run_score(dig(1,2,3,4), 1'b0, '0, "over_ignored");
    check("over_turns", int'(turns_used), 1);

    do_load(dig(1,2,3,4));
    check("load_clear_win", int'(win), 0);
    check("load_clear_exact", int'(exact), 0);
    check("load_clear_turns", int'(turns_used), 0);
    run_score(dig(4,3,2,1), 1'b1, {3'd0, 3'd4}, "reverse");
    check("reverse_win", int'(win), 0);
    check("reverse_reveal", int'(reveal), 0);
    run_score(dig(1,2,3,4), 1'b1, {3'd4, 3'd0}, "ready_after_reverse");
    check("second_turn", int'(turns_used), 2);

    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].secret);
      run_score(vecs[i].guess, 1'b1, {3'(vecs[i].ex), 3'(vecs[i].pa)}, "vec");
      check("vec_exact_hold", int'(exact), vecs[i].ex);
      check("vec_partial_hold", int'(partial), vecs[i].pa);
    end

    // Run out of turns.
    do_load(dig(0,0,0,0));
    for (int t = 1; t <= MT; t++) begin
      run_score(dig(5,5,5,5), 1'b1, '0, "lose_turn");
      check("lose_turns", int'(turns_used), t);
      check("lose_flag", int'(lose), (t == MT) ? 1 : 0);
    end
    check("lose_win", int'(win), 0);
    run_score(dig(5,5,5,5), 1'b0, '0, "after_lose_ignored");

    // Second request while scoring is dropped; latched guess is unaffected.
    do_load(dig(0,1,2,3));
    exp_q.push_back({3'd1, 3'd1});
    drive_req(dig(0,0,1,1));
    @(negedge clk);
    @(negedge clk);
    drive_req(dig(5,5,5,5));
    pulses = 0;
    for (int i = 0; i < LAT + 6; i++) begin
      if (score_valid) pulses++;
      @(negedge clk);
    end
    check("double_req_pulses", pulses, 1);

    // new_game mid-COUNT aborts scoring, then play the generated secret.
    do_load(dig(1,2,3,4));
    drive_req(dig(1,2,3,4));
    repeat (3) @(negedge clk);
    do_new_game(gen);
    check("abort_turns", int'(turns_used), 0);
    check("abort_win", int'(win), 0);
    repeat (LAT) @(negedge clk);
    run_score(gen, 1'b1, {3'd4, 3'd0}, "gen_win");
    check("gen_reveal", int'(reveal), int'(gen));
    check("gen_win_flag", int'(win), 1);

    // Reset mid-COUNT with non-zero outputs.
    do_load(dig(2,2,2,5));
    run_score(dig(2,5,5,2), 1'b1, {3'd1, 3'd2}, "pre_reset");
    drive_req(dig(2,2,2,2));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midcount_reset");
    run_score(dig(0,0,0,0), 1'b0, '0, "post_reset_ignored");

    // Randomized loaded secrets (any 3-bit digit) and generated secrets.
    for (int i = 0; i < 30; i++) begin
      s = 12'($urandom_range(0, 4095));
      g = ($urandom_range(0, 3) == 0) ? s : 12'($urandom_range(0, 4095));
      sc = model_score(s, g);
      do_load(s);
      run_score(g, 1'b1, sc, "rand");
      check("rand_win", int'(win), (sc[5:3] == 3'd4) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      do_new_game(gen);
      for (int k = 0; k < 4; k++) g[3*k +: 3] = 3'($urandom_range(0, 7));
      run_score(g, 1'b1, model_score(gen, g), "gen_rand");
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
